piso_shift_serializer: RTL and testbench



---
 rtl/piso_shift_serializer_if.sv | 56 +++++
 rtl/piso_shift_serializer.sv | 149 ++++++++++++++
 tb/tb_piso_shift_serializer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_shift_serializer_if.sv
// -----------------------------------------------------------------------------
// piso_shift_serializer_if
//
// Purpose : Bundles the load handshake, shift enable and serial output of the
//           parallel-in / serial-out serializer.
//
// Signals :
//   din         [WIDTH] parallel word to transmit
//   load_valid          din holds a word to be transmitted
//   load_ready          serializer can accept a word (holding register empty)
//   en                  shift enable; 0 freezes the shifter
//   sout                serial data bit (0 when sout_valid = 0)
//   sout_valid          sout carries a data bit
//   sout_last           sout carries the final bit of a word
//   busy                shifter or holding register occupied
//
// Modports:
//   master : word producer / link consumer (testbench or upstream logic)
//   slave  : the serializer itself
// -----------------------------------------------------------------------------
interface piso_shift_serializer_if #(
  parameter int WIDTH = 4
);

  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             en;
  logic             sout;
  logic             sout_valid;
  logic             sout_last;
  logic             busy;

  modport master (
    output din,
    output load_valid,
    output en,
    input  load_ready,
    input  sout,
    input  sout_valid,
    input  sout_last,
    input  busy
  );

  modport slave (
    input  din,
    input  load_valid,
    input  en,
    output load_ready,
    output sout,
    output sout_valid,
    output sout_last,
    output busy
  );

endinterface : piso_shift_serializer_if

// File: rtl/piso_shift_serializer.sv
// -----------------------------------------------------------------------------
// piso_shift_serializer
//
// Purpose : Parallel-in, serial-out shift register. Converts a WIDTH-bit word
//           into a one-bit-per-clock stream for the bit-serial link. A
//           one-entry holding register lets words stream back-to-back with no
//           idle bit between them; en pauses shifting without losing data.
//
// Parameters:
//   WIDTH     word width in bits (>= 2)
//   LSB_FIRST 0: bit WIDTH-1 transmitted first, 1: bit 0 transmitted first
//
// Ports:
//   clk  system clock, rising edge
//   clr  asynchronous, active-low reset; clears all state immediately
//   bus  piso_shift_serializer_if.slave (din, load_valid, load_ready, en,
//        sout, sout_valid, sout_last, busy)
// -----------------------------------------------------------------------------
module piso_shift_serializer #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     clr,
  piso_shift_serializer_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state,     state_n;
  logic [WIDTH-1:0]   shift_reg, shift_n;
  logic [CNT_W-1:0]   bit_cnt,   bit_cnt_n;
  logic [WIDTH-1:0]   hold_reg,  hold_n;
  logic               hold_full, hold_full_n;

  logic               accept;
  logic               end_of_word;
  logic [WIDTH-1:0]   shifted;
  logic               out_bit;

  // The holding register is the only back-pressure source: a word can always
  // be taken while it is empty, either straight into the shifter or into hold.
  assign bus.load_ready = !hold_full;
  assign accept         = bus.load_valid && !hold_full;

  // Last bit of the current word is leaving on this edge.
  assign end_of_word    = (state == SHIFT) && bus.en && (bit_cnt == '0);

  // Move one place toward the output end, zero-filled.
  assign shifted = LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);
  assign out_bit = LSB_FIRST ? shift_reg[0] : shift_reg[WIDTH-1];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is
    // inferred when a path leaves it unassigned.
    state_n     = state;
    shift_n     = shift_reg;
    bit_cnt_n   = bit_cnt;
    hold_n      = hold_reg;
    hold_full_n = hold_full;

    unique case (state)
      IDLE: begin
        // en is ignored here: an accepted word always starts immediately.
        if (accept) begin
          shift_n   = bus.din;
          bit_cnt_n = CNT_RELOAD;
          state_n   = SHIFT;
        end
      end

      SHIFT: begin
        if (bus.en) begin
          if (bit_cnt != '0) begin
            shift_n   = shifted;
            bit_cnt_n = bit_cnt - 1'b1;
          end else if (hold_full) begin
            // Queued word follows with no gap; frees the holding register.
            shift_n     = hold_reg;
            hold_full_n = 1'b0;
            bit_cnt_n   = CNT_RELOAD;
          end else if (accept) begin
            // Word offered exactly at end of word bypasses the holding register.
            shift_n   = bus.din;
            bit_cnt_n = CNT_RELOAD;
          end else begin
            state_n = IDLE;
          end
        end

        // Any accept not consumed by the direct-load path above is queued.
        // accept already implies hold_full = 0, and an en=0 stall still
        // allows queuing.
        if (accept && !end_of_word) begin
          hold_n      = bus.din;
          hold_full_n = 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    // NOTE: data registers are reset along with control so a reset mid-word
    // discards the partial word and leaves no stale bits to re-emit.
    if (!clr) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from the
      // same pre-edge values, independent of statement order.
      state     <= state_n;
      shift_reg <= shift_n;
      bit_cnt   <= bit_cnt_n;
      hold_reg  <= hold_n;
      hold_full <= hold_full_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (Moore, from registered state only)
  // ---------------------------------------------------------------------------
  assign bus.sout_valid = (state == SHIFT);
  assign bus.sout       = (state == SHIFT) && out_bit;
  assign bus.sout_last  = (state == SHIFT) && (bit_cnt == '0);
  assign bus.busy       = (state == SHIFT) || hold_full;

endmodule : piso_shift_serializer

// File: tb/tb_piso_shift_serializer.sv
// -----------------------------------------------------------------------------
// tb_piso_shift_serializer
//
// Directed bench for piso_shift_serializer. Two instances share clk/clr:
//   dut4 : WIDTH=4, MSB first
//   dut8 : WIDTH=8, LSB first
// Observed outputs are packed per cycle as {sout, sout_valid, sout_last,
// load_ready, busy} and compared against hand-computed vectors.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_piso_shift_serializer;

  logic clk;
  logic clr;

  int tests_run;
  int tests_failed;

  piso_shift_serializer_if #(.WIDTH(4)) bus4 ();
  piso_shift_serializer_if #(.WIDTH(8)) bus8 ();

  piso_shift_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut4 (
    .clk (clk),
    .clr (clr),
    .bus (bus4.slave)
  );

  piso_shift_serializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut8 (
    .clk (clk),
    .clr (clr),
    .bus (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] obs4();
    return {bus4.sout, bus4.sout_valid, bus4.sout_last, bus4.load_ready, bus4.busy};
  endfunction

  function automatic logic [4:0] obs8();
    return {bus8.sout, bus8.sout_valid, bus8.sout_last, bus8.load_ready, bus8.busy};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    logic [4:0] got;
    clr = 1'b1;
    #1 clr = 1'b0;
    tick();
    tick();
    got = obs4();
    tests_run++;
    if (got !== 5'b00010) begin
      tests_failed++;
      $display("FAIL reset_dut4 got %b want %b (sout,valid,last,ready,busy)", got, 5'b00010);
    end
    got = obs8();
    tests_run++;
    if (got !== 5'b00010) begin
      tests_failed++;
      $display("FAIL reset_dut8 got %b want %b (sout,valid,last,ready,busy)", got, 5'b00010);
    end
    clr = 1'b1;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_word();
    logic [4:0] exp_v [6];
    logic       lv    [6];
    logic [4:0] got;
    exp_v = '{5'b11011, 5'b01011, 5'b11011, 5'b11111, 5'b00010, 5'b00010};
    lv    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    bus4.din = 4'b1011;
    bus4.en  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus4.load_valid = lv[k];
      tick();
      got = obs4();
      tests_run++;
      if (got !== exp_v[k]) begin
        tests_failed++;
        $display("FAIL single_word[%0d] got %b want %b (sout,valid,last,ready,busy)", k, got, exp_v[k]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [4:0] exp_v [9];
    logic       lv    [9];
    logic [3:0] dv    [9];
    logic [4:0] got;
    exp_v = '{5'b11011, 5'b01001, 5'b11001, 5'b11101, 5'b01011,
              5'b11011, 5'b11011, 5'b01111, 5'b00010};
    lv    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    dv    = '{4'b1011, 4'b0110, 4'b0000, 4'b0000, 4'b0000,
              4'b0000, 4'b0000, 4'b0000, 4'b0000};
    bus4.en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      bus4.load_valid = lv[k];
      bus4.din        = dv[k];
      tick();
      got = obs4();
      tests_run++;
      if (got !== exp_v[k]) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d] got %b want %b (sout,valid,last,ready,busy)", k, got, exp_v[k]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_direct_load();
    logic [4:0] exp_v [9];
    logic       lv    [9];
    logic [3:0] dv    [9];
    logic [4:0] got;
    exp_v = '{5'b11011, 5'b11011, 5'b01011, 5'b01111, 5'b01011,
              5'b01011, 5'b11011, 5'b11111, 5'b00010};
    lv    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    dv    = '{4'b1100, 4'b1111, 4'b1111, 4'b1111, 4'b0011,
              4'b1111, 4'b1111, 4'b1111, 4'b1111};
    bus4.en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      bus4.load_valid = lv[k];
      bus4.din        = dv[k];
      tick();
      got = obs4();
      tests_run++;
      if (got !== exp_v[k]) begin
        tests_failed++;
        $display("FAIL direct_load[%0d] got %b want %b (sout,valid,last,ready,busy)", k, got, exp_v[k]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // en is low on the loading edge too: a load in IDLE must ignore en.
  task automatic test_stall();
    logic [4:0] exp_v [8];
    logic       lv    [8];
    logic       ev    [8];
    logic [4:0] got;
    exp_v = '{5'b11011, 5'b11011, 5'b11011, 5'b11011,
              5'b01011, 5'b01011, 5'b11111, 5'b00010};
    lv    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    ev    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    bus4.din = 4'b1001;
    for (int k = 0; k < 8; k++) begin
      bus4.load_valid = lv[k];
      bus4.en         = ev[k];
      tick();
      got = obs4();
      tests_run++;
      if (got !== exp_v[k]) begin
        tests_failed++;
        $display("FAIL stall[%0d] got %b want %b (sout,valid,last,ready,busy)", k, got, exp_v[k]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_lsb_first();
    logic [4:0] exp_v [9];
    logic [4:0] got;
    exp_v = '{5'b11011, 5'b01011, 5'b11011, 5'b01011, 5'b01011,
              5'b11011, 5'b01011, 5'b11111, 5'b00010};
    bus8.din = 8'hA5;
    bus8.en  = 1'b1;
    for (int k = 0; k < 9; k++) begin
      bus8.load_valid = (k == 0);
      tick();
      got = obs8();
      tests_run++;
      if (got !== exp_v[k]) begin
        tests_failed++;
        $display("FAIL lsb_first[%0d] got %b want %b (sout,valid,last,ready,busy)", k, got, exp_v[k]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_word();
    logic [4:0] exp_v [5];
    logic [4:0] got;
    bus4.en = 1'b1;
    bus4.load_valid = 1'b1;
    bus4.din        = 4'b1111;
    tick();
    bus4.din        = 4'b1010;
    tick();
    bus4.load_valid = 1'b0;
    got = obs4();
    tests_run++;
    if (got !== 5'b11001) begin
      tests_failed++;
      $display("FAIL reset_mid_pre got %b want %b (sout,valid,last,ready,busy)", got, 5'b11001);
    end
    // Assert clr between edges: outputs must clear without a clock.
    #2 clr = 1'b0;
    #1;
    got = obs4();
    tests_run++;
    if (got !== 5'b00010) begin
      tests_failed++;
      $display("FAIL reset_mid_async got %b want %b (sout,valid,last,ready,busy)", got, 5'b00010);
    end
    tick();
    clr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      got = obs4();
      tests_run++;
      if (got !== 5'b00010) begin
        tests_failed++;
        $display("FAIL reset_mid_residual[%0d] got %b want %b (sout,valid,last,ready,busy)", k, got, 5'b00010);
      end
    end
    exp_v = '{5'b01011, 5'b11011, 5'b01011, 5'b11111, 5'b00010};
    bus4.din = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      bus4.load_valid = (k == 0);
      tick();
      got = obs4();
      tests_run++;
      if (got !== exp_v[k]) begin
        tests_failed++;
        $display("FAIL reset_mid_reload[%0d] got %b want %b (sout,valid,last,ready,busy)", k, got, exp_v[k]);
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    bus4.din        = '0;
    bus4.load_valid = 1'b0;
    bus4.en         = 1'b0;
    bus8.din        = '0;
    bus8.load_valid = 1'b0;
    bus8.en         = 1'b0;

    test_reset();
    test_single_word();
    test_back_to_back();
    test_direct_load();
    test_stall();
    test_lsb_first();
    test_reset_mid_word();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_piso_shift_serializer
